// File: rtl/camera_sched_pkg.sv
// Shared encodings for the camera frame scheduler: CPU command codes,
// camera-side command constants and the scheduler state encoding.
package camera_sched_pkg;

   localparam logic [2:0] CMD_SET_BASE0   = 3'd0;
   localparam logic [2:0] CMD_SET_BASE1   = 3'd1;
   localparam logic [2:0] CMD_ENABLE      = 3'd2;
   localparam logic [2:0] CMD_STATUS      = 3'd3;
   localparam logic [2:0] CMD_CLAIM       = 3'd4;
   localparam logic [2:0] CMD_RELEASE     = 3'd5;
   localparam logic [2:0] CMD_FRAME_COUNT = 3'd6;
   localparam logic [2:0] CMD_ERROR_COUNT = 3'd7;

   localparam logic [31:0] CAM_SET_BASE    = 32'd5;
   localparam logic [31:0] CAM_GRAB        = 32'd6;
   localparam logic [31:0] CAM_SINGLE_SHOT = 32'd2;
   localparam logic [31:0] CAM_DONE        = 32'd7;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STALL    = 3'd1,
      SET_ADDR = 3'd2,
      START    = 3'd3,
      WAIT     = 3'd4,
      POLL     = 3'd5,
      DONE     = 3'd6
   } schedState_t;

endpackage

// File: rtl/camera_ci_master.sv
// Single-transaction CI master toward the camera: holds start with stable
// operands until camCiDone, captures the result and pulses ack one cycle later.
module camera_ci_master (
   input  logic        clock,
   input  logic        resetN,
   input  logic        reqValid,
   input  logic [31:0] reqCmd,
   input  logic [31:0] reqOperand,
   output logic        ack,
   output logic [31:0] ackResult,
   output logic        camCiStart,
   output logic [31:0] camCiValueA,
   output logic [31:0] camCiValueB,
   input  logic [31:0] camCiResult,
   input  logic        camCiDone
);

   // The ack cycle doubles as the mandatory idle gap between transactions.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         camCiStart  <= 1'b0;
         camCiValueA <= '0;
         camCiValueB <= '0;
         ack         <= 1'b0;
         ackResult   <= '0;
      end else begin
         ack <= 1'b0;
         if (camCiStart) begin
            if (camCiDone) begin
               camCiStart <= 1'b0;
               ack        <= 1'b1;
               ackResult  <= camCiResult;
            end
         end else if (reqValid && !ack) begin
            camCiStart  <= 1'b1;
            camCiValueA <= reqCmd;
            camCiValueB <= reqOperand;
         end
      end
   end

endmodule

// File: rtl/camera_frame_scheduler.sv
// Ping-pong frame-buffer scheduler: sequences the camera grabber and hands the
// latest finished buffer to the CPU. Define SCHED_TIMEOUT_EN for grab timeouts.
//
// state    | meaning
// IDLE     | disabled, no grab in flight
// STALL    | next fill buffer is held by the CPU, waiting for release
// SET_ADDR | programming camera base address
// START    | triggering single-shot grab
// WAIT     | poll interval countdown
// POLL     | querying camera for completion
// DONE     | publish finished buffer, swap fill index
module camera_frame_scheduler
   import camera_sched_pkg::*;
#(
   parameter logic [7:0]  customInstructionId = 8'd0,
   parameter logic [7:0]  cameraCiId          = 8'd1,
   parameter int          pollInterval        = 64,
   parameter logic [15:0] timeoutPolls        = 16'd20000
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        ciStart,
   input  logic        ciCke,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic [31:0] ciResult,
   output logic        ciDone,
   output logic        camCiStart,
   output logic        camCiCke,
   output logic [7:0]  camCiN,
   output logic [31:0] camCiValueA,
   output logic [31:0] camCiValueB,
   input  logic [31:0] camCiResult,
   input  logic        camCiDone
);

   localparam int TIMER_W = $clog2(pollInterval);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(pollInterval - 1);
   localparam logic [15:0] TIMEOUT_LAST = timeoutPolls - 16'd1;

   schedState_t state, stateNext;
   logic [31:0] base0, base1, frameCount, errorCount;
   logic        enable, fillIdx, readyIdx, readyValid, claimed, claimIdx, errorFlag, busy;
   logic [7:0]  overrunCount;
   logic [TIMER_W-1:0] pollTimer;
   logic [15:0] pollCount;
   logic [2:0]  cmd;
   logic        claimNow, releaseNow, claimedNext, claimIdxNext, fillBlocked, nextFillBlocked;
   logic        camReq, camAck, pollMiss, timeoutNow, unusedBits;
   logic [31:0] camReqCmd, camReqOperand, camAckResult;

   assign ciDone     = ciStart & ciCke & (ciN == customInstructionId);
   assign cmd        = ciValueA[2:0];
   assign claimNow   = ciDone & (cmd == CMD_CLAIM);
   assign releaseNow = ciDone & (cmd == CMD_RELEASE);
   assign busy       = (state != IDLE);
   assign camCiCke   = camCiStart;
   assign camCiN     = cameraCiId;
   assign pollMiss   = (state == POLL) & camAck & ~camAckResult[0];
   assign unusedBits = ^{ciValueA[31:3], ciValueB[1], camAckResult[31:1]};

   // Ownership as it will be after this cycle, so a same-cycle claim/release is seen.
   always_comb begin
      claimedNext  = claimed;
      claimIdxNext = claimIdx;
      if (releaseNow) begin
         claimedNext = 1'b0;
      end else if (claimNow && readyValid) begin
         claimedNext  = 1'b1;
         claimIdxNext = readyIdx;
      end
   end

   assign fillBlocked     = claimedNext & (claimIdxNext == fillIdx);
   assign nextFillBlocked = claimedNext & (claimIdxNext == ~fillIdx);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:     if (enable) stateNext = fillBlocked ? STALL : SET_ADDR;
         STALL:    if (!enable) stateNext = IDLE;
                   else if (!fillBlocked) stateNext = SET_ADDR;
         SET_ADDR: if (camAck) stateNext = START;
         START:    if (camAck) stateNext = WAIT;
         WAIT:     if (pollTimer == '0) stateNext = POLL;
         POLL:     if (camAck) begin
                      if (camAckResult[0]) stateNext = DONE;
                      else if (timeoutNow) stateNext = SET_ADDR;
                      else stateNext = WAIT;
                   end
         DONE:     if (!enable) stateNext = IDLE;
                   else stateNext = nextFillBlocked ? STALL : SET_ADDR;
         default:  stateNext = IDLE;
      endcase
   end

   always_comb begin
      camReq        = 1'b0;
      camReqCmd     = '0;
      camReqOperand = '0;
      case (state)
         SET_ADDR: begin
            camReq        = 1'b1;
            camReqCmd     = CAM_SET_BASE;
            camReqOperand = fillIdx ? base1 : base0;
         end
         START: begin
            camReq        = 1'b1;
            camReqCmd     = CAM_GRAB;
            camReqOperand = CAM_SINGLE_SHOT;
         end
         POLL: begin
            camReq    = 1'b1;
            camReqCmd = CAM_DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         base0        <= '0;
         base1        <= '0;
         enable       <= 1'b0;
         fillIdx      <= 1'b0;
         readyIdx     <= 1'b0;
         readyValid   <= 1'b0;
         claimed      <= 1'b0;
         claimIdx     <= 1'b0;
         frameCount   <= '0;
         overrunCount <= '0;
         pollTimer    <= '0;
         pollCount    <= '0;
      end else begin
         if (ciDone) begin
            case (cmd)
               CMD_SET_BASE0: base0  <= {ciValueB[31:2], 2'b00};
               CMD_SET_BASE1: base1  <= {ciValueB[31:2], 2'b00};
               CMD_ENABLE:    enable <= ciValueB[0];
               default: ;
            endcase
         end
         claimed  <= claimedNext;
         claimIdx <= claimIdxNext;
         if (state == DONE) begin
            if (readyValid && !claimNow && overrunCount != 8'hFF)
               overrunCount <= overrunCount + 8'd1;
            readyIdx   <= fillIdx;
            readyValid <= 1'b1;
            frameCount <= frameCount + 32'd1;
            fillIdx    <= ~fillIdx;
         end else if (claimNow) begin
            readyValid <= 1'b0;
         end
         if (state == START && camAck) begin
            pollTimer <= TIMER_LOAD;
            pollCount <= '0;
         end else if (pollMiss) begin
            pollTimer <= TIMER_LOAD;
            if (pollCount != TIMEOUT_LAST) pollCount <= pollCount + 16'd1;
         end else if (state == WAIT && pollTimer != '0) begin
            pollTimer <= pollTimer - 1'b1;
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   logic errReadNow;
   assign errReadNow = ciDone & (cmd == CMD_ERROR_COUNT);
   assign timeoutNow = pollMiss & (pollCount == TIMEOUT_LAST);

   // A read clears the count, but a timeout landing in the same cycle is kept.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         errorCount <= '0;
         errorFlag  <= 1'b0;
      end else if (errReadNow) begin
         errorCount <= timeoutNow ? 32'd1 : 32'd0;
         errorFlag  <= timeoutNow;
      end else if (timeoutNow) begin
         if (errorCount != 32'hFFFF_FFFF) errorCount <= errorCount + 32'd1;
         errorFlag <= 1'b1;
      end
   end
`else
   assign timeoutNow = 1'b0;
   assign errorCount = '0;
   assign errorFlag  = 1'b0;
`endif

   always_comb begin
      ciResult = '0;
      if (ciDone) begin
         case (cmd)
            CMD_STATUS:      ciResult = {16'd0, overrunCount, 4'd0, errorFlag, busy, readyIdx, readyValid};
            CMD_CLAIM:       ciResult = readyValid ? (readyIdx ? base1 : base0) : 32'd0;
            CMD_FRAME_COUNT: ciResult = frameCount;
            CMD_ERROR_COUNT: ciResult = errorCount;
            default:         ciResult = '0;
         endcase
      end
   end

   camera_ci_master uCiMaster (
      .clock       (clock),
      .resetN      (resetN),
      .reqValid    (camReq),
      .reqCmd      (camReqCmd),
      .reqOperand  (camReqOperand),
      .ack         (camAck),
      .ackResult   (camAckResult),
      .camCiStart  (camCiStart),
      .camCiValueA (camCiValueA),
      .camCiValueB (camCiValueB),
      .camCiResult (camCiResult),
      .camCiDone   (camCiDone)
   );

endmodule

// File: tb/tb_camera_frame_scheduler.sv
// Directed bench for camera_frame_scheduler with a behavioural camera CI slave.
// Timeout scenario is compiled only when SCHED_TIMEOUT_EN is defined.
module tb_camera_frame_scheduler;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        ciStart = 1'b0, ciCke = 1'b0;
   logic [7:0]  ciN = 8'd0;
   logic [31:0] ciValueA = '0, ciValueB = '0;
   logic [31:0] ciResult;
   logic        ciDone;
   logic        camCiStart, camCiCke;
   logic [7:0]  camCiN;
   logic [31:0] camCiValueA, camCiValueB;
   logic [31:0] camCiResult = '0;
   logic        camCiDone = 1'b0;

   int compared = 0;
   int mismatched = 0;

   int camLatency = 0;
   int pollsToComplete = 0;
   logic garbage = 1'b0;

   int holdCnt = 0, pollsThisGrab = 0, completions = 0, gapViolations = 0, unstable = 0;
   logic prevDone = 1'b0;
   logic [31:0] firstA, firstB;
   logic [31:0] logA[$];
   logic [31:0] logB[$];
   int logHold[$];

   always #5 clock = ~clock;

   camera_frame_scheduler #(
      .customInstructionId (8'd0),
      .cameraCiId          (8'd1),
      .pollInterval        (4),
      .timeoutPolls        (16'd4)
   ) dut (
      .clock       (clock),
      .resetN      (resetN),
      .ciStart     (ciStart),
      .ciCke       (ciCke),
      .ciN         (ciN),
      .ciValueA    (ciValueA),
      .ciValueB    (ciValueB),
      .ciResult    (ciResult),
      .ciDone      (ciDone),
      .camCiStart  (camCiStart),
      .camCiCke    (camCiCke),
      .camCiN      (camCiN),
      .camCiValueA (camCiValueA),
      .camCiValueB (camCiValueB),
      .camCiResult (camCiResult),
      .camCiDone   (camCiDone)
   );

   // Camera slave: answers after camLatency wait cycles, logs every transaction.
   always @(negedge clock) begin
      if (!resetN) begin
         camCiDone = 1'b0;
         camCiResult = '0;
         holdCnt = 0;
         prevDone = 1'b0;
         pollsThisGrab = 0;
         completions = 0;
         logA.delete();
         logB.delete();
         logHold.delete();
      end else begin
         if (camCiStart && prevDone) gapViolations++;
         prevDone = 1'b0;
         camCiDone = 1'b0;
         camCiResult = '0;
         if (camCiStart) begin
            if (holdCnt == 0) begin
               firstA = camCiValueA;
               firstB = camCiValueB;
            end else if (camCiValueA !== firstA || camCiValueB !== firstB) begin
               unstable++;
            end
            if (holdCnt >= camLatency) begin
               camCiDone = 1'b1;
               prevDone = 1'b1;
               logA.push_back(camCiValueA);
               logB.push_back(camCiValueB);
               logHold.push_back(holdCnt + 1);
               if (camCiValueA == 32'd6) pollsThisGrab = 0;
               if (camCiValueA == 32'd7) begin
                  pollsThisGrab++;
                  if (pollsToComplete != 0 && pollsThisGrab >= pollsToComplete) begin
                     camCiResult = 32'd1;
                     completions++;
                  end
               end
               holdCnt = 0;
            end else begin
               holdCnt++;
               camCiResult = garbage ? 32'd1 : 32'd0;
            end
         end else begin
            holdCnt = 0;
         end
      end
   end

   function automatic int countA(input logic [31:0] a);
      int c = 0;
      foreach (logA[i]) if (logA[i] == a) c++;
      return c;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic cpuCmd(input logic [2:0] cmd, input logic [31:0] valB, output logic [31:0] res);
      @(negedge clock);
      ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
      ciValueA = {29'd0, cmd}; ciValueB = valB;
      #1 res = ciResult;
      @(negedge clock);
      ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0; ciValueB = '0;
   endtask

   // kind 0: log entries, 1: completed frames, 2: SET_BASE transactions
   task automatic waitEvent(input int kind, input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((kind == 0 && logA.size() >= n) || (kind == 1 && completions >= n) ||
             (kind == 2 && countA(32'd5) >= n)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic doReset;
      resetN = 1'b0;
      ciStart = 1'b0; ciCke = 1'b0; ciN = 8'd0; ciValueA = '0; ciValueB = '0;
      camLatency = 0; pollsToComplete = 0; garbage = 1'b0;
      tick(2);
      resetN = 1'b1;
      tick(1);
   endtask

   task automatic setBases;
      logic [31:0] r;
      cpuCmd(3'd0, 32'h0000_1003, r);
      cpuCmd(3'd1, 32'h0000_2000, r);
   endtask

   task automatic test_reset;
      logic [31:0] r;
      resetN = 1'b0;
      tick(2);
      compared++; if (camCiStart !== 1'b0) begin mismatched++; $display("FAIL reset_camCiStart: got %b want 0", camCiStart); end
      compared++; if (camCiCke !== 1'b0) begin mismatched++; $display("FAIL reset_camCiCke: got %b want 0", camCiCke); end
      compared++; if (camCiN !== 8'd1) begin mismatched++; $display("FAIL reset_camCiN: got %h want 01", camCiN); end
      compared++; if (camCiValueA !== 32'd0 || camCiValueB !== 32'd0) begin mismatched++; $display("FAIL reset_camAB: got %h/%h want 0/0", camCiValueA, camCiValueB); end
      resetN = 1'b1;
      tick(1);
      ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd3; ciValueA = 32'd6;
      #1;
      compared++; if (ciDone !== 1'b0 || ciResult !== 32'd0) begin mismatched++; $display("FAIL decode_wrong_id: got done=%b res=%h want 0/0", ciDone, ciResult); end
      ciN = 8'd0; ciCke = 1'b0;
      #1;
      compared++; if (ciDone !== 1'b0) begin mismatched++; $display("FAIL decode_no_cke: got %b want 0", ciDone); end
      ciCke = 1'b1;
      #1;
      compared++; if (ciDone !== 1'b1) begin mismatched++; $display("FAIL decode_selected: got %b want 1", ciDone); end
      tick(1);
      ciStart = 1'b0; ciCke = 1'b0; ciValueA = '0;
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL reset_status: got %h want 0", r); end
      cpuCmd(3'd4, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL reset_claim: got %h want 0", r); end
      cpuCmd(3'd7, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL reset_errcount: got %h want 0", r); end
   endtask

   task automatic test_basic_grab;
      logic [31:0] r;
      bit ok;
      doReset();
      setBases();
      pollsToComplete = 3;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(0, 4, 400, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL basic_wait4: got %0d transactions want 4", logA.size()); end
      cpuCmd(3'd2, 32'd0, r);
      waitEvent(0, 5, 400, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL basic_wait5: got %0d transactions want 5", logA.size()); end
      tick(15);
      compared++; if (logA.size() != 5) begin mismatched++; $display("FAIL basic_txn_count: got %0d want 5", logA.size()); end
      if (logA.size() >= 5) begin
         compared++; if (logA[0] !== 32'd5 || logB[0] !== 32'h1000) begin mismatched++; $display("FAIL basic_set_addr: got %h/%h want 5/1000", logA[0], logB[0]); end
         compared++; if (logA[1] !== 32'd6 || logB[1] !== 32'd2) begin mismatched++; $display("FAIL basic_start: got %h/%h want 6/2", logA[1], logB[1]); end
         compared++; if (logA[2] !== 32'd7 || logA[3] !== 32'd7 || logA[4] !== 32'd7) begin mismatched++; $display("FAIL basic_polls: got %h %h %h want 7 7 7", logA[2], logA[3], logA[4]); end
      end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h1) begin mismatched++; $display("FAIL basic_status: got %h want 1", r); end
      cpuCmd(3'd6, 32'd0, r);
      compared++; if (r !== 32'd1) begin mismatched++; $display("FAIL basic_framecount: got %h want 1", r); end
      cpuCmd(3'd4, 32'd0, r);
      compared++; if (r !== 32'h1000) begin mismatched++; $display("FAIL basic_claim: got %h want 1000", r); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h0) begin mismatched++; $display("FAIL basic_status_claimed: got %h want 0", r); end
      cpuCmd(3'd5, 32'd0, r);
      compared++; if (r !== 32'h0) begin mismatched++; $display("FAIL basic_release: got %h want 0", r); end
   endtask

   task automatic test_overrun;
      logic [31:0] r;
      logic [31:0] setB[$];
      bit ok;
      doReset();
      setBases();
      pollsToComplete = 1;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(2, 3, 600, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL overrun_wait_set3: got %0d want 3", countA(32'd5)); end
      cpuCmd(3'd2, 32'd0, r);
      waitEvent(1, 3, 600, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL overrun_wait_frames: got %0d want 3", completions); end
      tick(15);
      compared++; if (logA.size() != 9) begin mismatched++; $display("FAIL overrun_txn_count: got %0d want 9", logA.size()); end
      foreach (logA[i]) if (logA[i] == 32'd5) setB.push_back(logB[i]);
      if (setB.size() == 3) begin
         compared++; if (setB[0] !== 32'h1000 || setB[1] !== 32'h2000 || setB[2] !== 32'h1000) begin mismatched++; $display("FAIL overrun_pingpong: got %h %h %h want 1000 2000 1000", setB[0], setB[1], setB[2]); end
      end else begin
         compared++; mismatched++; $display("FAIL overrun_setaddr_count: got %0d want 3", setB.size());
      end
      cpuCmd(3'd6, 32'd0, r);
      compared++; if (r !== 32'd3) begin mismatched++; $display("FAIL overrun_framecount: got %h want 3", r); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h201) begin mismatched++; $display("FAIL overrun_status: got %h want 201", r); end
   endtask

   task automatic test_claim_stall;
      logic [31:0] r;
      bit ok;
      bit seen;
      doReset();
      setBases();
      pollsToComplete = 1;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(2, 3, 600, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL stall_wait_set3: got %0d want 3", countA(32'd5)); end
      cpuCmd(3'd4, 32'd0, r);
      compared++; if (r !== 32'h2000) begin mismatched++; $display("FAIL stall_claim: got %h want 2000", r); end
      waitEvent(1, 3, 600, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL stall_wait_frames: got %0d want 3", completions); end
      tick(20);
      compared++; if (logA.size() != 9 || camCiStart !== 1'b0) begin mismatched++; $display("FAIL stall_no_activity: got %0d txns start=%b want 9/0", logA.size(), camCiStart); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h105) begin mismatched++; $display("FAIL stall_status: got %h want 105", r); end
      cpuCmd(3'd5, 32'd0, r);
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         @(negedge clock);
         if (camCiStart === 1'b1) seen = 1'b1;
      end
      compared++; if (!seen) begin mismatched++; $display("FAIL stall_release_latency: got start=%b want 1 within 2 cycles", camCiStart); end
      compared++; if (camCiValueA !== 32'd5 || camCiValueB !== 32'h2000) begin mismatched++; $display("FAIL stall_resume_cmd: got %h/%h want 5/2000", camCiValueA, camCiValueB); end
      cpuCmd(3'd2, 32'd0, r);
      cpuCmd(3'd5, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL stall_release_unclaimed: got %h want 0", r); end
   endtask

   task automatic test_hold_stable;
      logic [31:0] r;
      bit ok;
      doReset();
      setBases();
      camLatency = 5;
      garbage = 1'b1;
      pollsToComplete = 2;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(0, 1, 400, ok);
      cpuCmd(3'd2, 32'd0, r);
      waitEvent(1, 1, 800, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL hold_wait_frame: got %0d want 1", completions); end
      tick(20);
      compared++; if (logA.size() != 4) begin mismatched++; $display("FAIL hold_txn_count: got %0d want 4", logA.size()); end
      if (logHold.size() >= 3) begin
         compared++; if (logHold[2] != 6) begin mismatched++; $display("FAIL hold_poll_length: got %0d want 6", logHold[2]); end
      end
      compared++; if (unstable != 0) begin mismatched++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
      cpuCmd(3'd6, 32'd0, r);
      compared++; if (r !== 32'd1) begin mismatched++; $display("FAIL hold_framecount: got %h want 1", r); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h1) begin mismatched++; $display("FAIL hold_status: got %h want 1", r); end
   endtask

`ifdef SCHED_TIMEOUT_EN
   task automatic test_timeout;
      logic [31:0] r;
      bit ok;
      doReset();
      setBases();
      pollsToComplete = 0;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(2, 2, 600, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL timeout_reissue: got %0d set_addr want 2", countA(32'd5)); end
      if (logA.size() >= 7) begin
         compared++; if (logA[2] !== 32'd7 || logA[5] !== 32'd7 || logA[6] !== 32'd5 || logB[6] !== 32'h1000) begin mismatched++; $display("FAIL timeout_sequence: got %h %h %h/%h want 7 7 5/1000", logA[2], logA[5], logA[6], logB[6]); end
      end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'hC) begin mismatched++; $display("FAIL timeout_status: got %h want c", r); end
      cpuCmd(3'd7, 32'd0, r);
      compared++; if (r !== 32'd1) begin mismatched++; $display("FAIL timeout_errcount: got %h want 1", r); end
      cpuCmd(3'd7, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL timeout_errcount_clear: got %h want 0", r); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h4) begin mismatched++; $display("FAIL timeout_status_clear: got %h want 4", r); end
   endtask
`else
   task automatic test_no_timeout;
      logic [31:0] r;
      bit ok;
      doReset();
      setBases();
      pollsToComplete = 0;
      cpuCmd(3'd2, 32'd1, r);
      waitEvent(0, 10, 800, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL notimeout_polls: got %0d txns want 10", logA.size()); end
      compared++; if (countA(32'd5) != 1) begin mismatched++; $display("FAIL notimeout_no_reissue: got %0d set_addr want 1", countA(32'd5)); end
      cpuCmd(3'd7, 32'd0, r);
      compared++; if (r !== 32'd0) begin mismatched++; $display("FAIL notimeout_errcount: got %h want 0", r); end
      cpuCmd(3'd3, 32'd0, r);
      compared++; if (r !== 32'h4) begin mismatched++; $display("FAIL notimeout_status: got %h want 4", r); end
   endtask
`endif

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_grab();
      test_overrun();
      test_claim_stall();
      test_hold_stable();
`ifdef SCHED_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      compared++; if (gapViolations != 0) begin mismatched++; $display("FAIL idle_gap: got %0d back-to-back starts want 0", gapViolations); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
